// File: rtl/key_value_entry.sv
// Key entry front end: synchronises and debounces KEY[3:0], then turns presses
// into inc/dec/clear/lock commands on a registered nibble with auto-repeat.
module key_value_entry #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [3:0] KEY,
  output logic [3:0] VALUE,
  output logic [3:0] PRESS,
  output logic [3:0] LEDR,
  output logic       LOCK,
  output logic       WRAP
);

  // state  | meaning
  // IDLE   | no auto-repeat pending
  // DELAY  | key held, waiting REPEAT_DELAY before first repeat step
  // REPEAT | key held, stepping every REPEAT_PERIOD cycles

  localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_ONE   = DB_W'(1);
  localparam logic [TMR_W-1:0] DLY_LAST = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] PER_LAST = TMR_W'(REPEAT_PERIOD - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } rpt_state_t;

  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [DB_W-1:0]  r_db_cnt [4];
  logic [3:0]       r_db;
  logic [3:0]       r_press;
  logic [3:0]       r_rel;
  logic [3:0]       r_value;
  logic             r_wrap;
  logic             r_lock;
  rpt_state_t       r_state;
  logic             r_dir_dn;
  logic [TMR_W-1:0] r_timer;

  logic [3:0] w_pressed;
  logic       w_exit;
  logic       w_step;
  logic       w_start;
  logic       w_up;
  logic       w_dn;

  // Synchronisers reset to the released level so a held key re-debounces.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= KEY;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pressed = ~r_sync2;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
      r_db    <= '0;
      r_press <= '0;
      r_rel   <= '0;
    end else begin
      r_press <= '0;
      r_rel   <= '0;
      for (int i = 0; i < 4; i++) begin
        if (w_pressed[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db_cnt[i] <= '0;
          r_db[i]     <= ~r_db[i];
          r_press[i]  <= ~r_db[i];
          r_rel[i]    <= r_db[i];
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_ONE;
        end
      end
    end
  end

  // Leaving auto-repeat outranks a step that falls due in the same cycle.
  assign w_exit = (r_state != ST_IDLE) &&
                  ((r_dir_dn ? r_rel[1] : r_rel[0]) ||
                   (r_dir_dn ? r_press[0] : r_press[1]) ||
                   r_lock || r_press[2]);

  assign w_step = !w_exit &&
                  (((r_state == ST_DELAY) && (r_timer == DLY_LAST)) ||
                   ((r_state == ST_REPEAT) && (r_timer == PER_LAST)));

  assign w_start = (r_state == ST_IDLE) && !r_lock &&
                   ((r_press[0] && !r_press[1] && !r_db[1]) ||
                    (r_press[1] && !r_press[0] && !r_db[0]));

  assign w_up = r_press[0] | (w_step & ~r_dir_dn);
  assign w_dn = r_press[1] | (w_step & r_dir_dn);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= ST_IDLE;
      r_dir_dn <= 1'b0;
      r_timer  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_timer <= '0;
          if (w_start) begin
            r_state  <= ST_DELAY;
            r_dir_dn <= r_press[1];
          end
        end
        ST_DELAY, ST_REPEAT: begin
          if (w_exit) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
          end else if (w_step) begin
            r_state <= ST_REPEAT;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + TMR_ONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_timer <= '0;
        end
      endcase
    end
  end

  // Steps in the toggle cycle still see the old lock state.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_value <= '0;
      r_wrap  <= 1'b0;
      r_lock  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      r_lock <= r_lock ^ r_press[3];
      if (r_press[2]) begin
        r_value <= '0;
      end else if (!r_lock && (w_up ^ w_dn)) begin
        if (w_up) begin
          r_value <= r_value + 4'd1;
          r_wrap  <= (r_value == 4'hF);
        end else begin
          r_value <= r_value - 4'd1;
          r_wrap  <= (r_value == 4'h0);
        end
      end
    end
  end

  assign VALUE = r_value;
  assign PRESS = r_press;
  assign LEDR  = r_db;
  assign LOCK  = r_lock;
  assign WRAP  = r_wrap;

endmodule

// File: tb/tb_key_value_entry.sv
// Bench for key_value_entry: cycle-level reference model compared every cycle,
// directed scenarios with literal checkpoints, then randomised key activity.
module tb_key_value_entry;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 5;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key   = 4'hF;
  logic [3:0] value;
  logic [3:0] press;
  logic [3:0] ledr;
  logic       lock;
  logic       wrap;

  key_value_entry #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .CLOCK_50(clk),
    .RESET_N (rst_n),
    .KEY     (key),
    .VALUE   (value),
    .PRESS   (press),
    .LEDR    (ledr),
    .LOCK    (lock),
    .WRAP    (wrap)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [3:0] m_k1, m_k2;
  logic [3:0] m_db, m_press, m_rel, m_val;
  logic       m_wrap, m_lock, m_act, m_dn;
  int         m_streak [4];
  int         m_age;

  // Running pulse / change totals
  int         press_tot [4];
  int         wrap_tot = 0;
  int         chg_tot  = 0;
  logic [3:0] prev_val = 4'h0;

  int s_press0, s_press1, s_wrap, s_chg;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    key   = 4'hF;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic press_key(input int k);
    key[k] = 1'b0;
    repeat (8) tick();
    key[k] = 1'b1;
    repeat (10) tick();
  endtask

  task automatic snap();
    s_press0 = press_tot[0];
    s_press1 = press_tot[1];
    s_wrap   = wrap_tot;
    s_chg    = chg_tot;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) press_tot[i] = 0;

    fork
      // Reference model: advances on every clock edge, resets asynchronously.
      forever begin : model
        logic [3:0] p, n_db, n_press, n_rel;
        logic       exit_now, step, up, dn, dir_rel, opp_press, start;
        int         nage;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          m_k1 = 4'hF; m_k2 = 4'hF;
          m_db = '0; m_press = '0; m_rel = '0; m_val = '0;
          m_wrap = 1'b0; m_lock = 1'b0; m_act = 1'b0; m_dn = 1'b0;
          m_age = 0;
          for (int i = 0; i < 4; i++) m_streak[i] = 0;
        end else begin
          p         = ~m_k2;
          dir_rel   = m_dn ? m_rel[1] : m_rel[0];
          opp_press = m_dn ? m_press[0] : m_press[1];
          exit_now  = m_act && (dir_rel || opp_press || m_lock || m_press[2]);
          nage      = m_age + 1;
          step      = m_act && !exit_now &&
                      ((nage == RD) || ((nage > RD) && (((nage - RD) % RP) == 0)));
          up        = m_press[0] | (step & !m_dn);
          dn        = m_press[1] | (step & m_dn);
          start     = !m_act && !m_lock &&
                      ((m_press[0] && !m_press[1] && !m_db[1]) ||
                       (m_press[1] && !m_press[0] && !m_db[0]));

          m_wrap = 1'b0;
          if (m_press[2]) m_val = 4'h0;
          else if (!m_lock && up && !dn) begin
            m_wrap = (m_val == 4'hF);
            m_val  = m_val + 4'd1;
          end else if (!m_lock && dn && !up) begin
            m_wrap = (m_val == 4'h0);
            m_val  = m_val - 4'd1;
          end
          m_lock = m_lock ^ m_press[3];

          if (start) begin
            m_act = 1'b1; m_age = 0; m_dn = m_press[1];
          end else if (exit_now) begin
            m_act = 1'b0; m_age = 0;
          end else if (m_act) begin
            m_age = nage;
          end

          n_db = m_db; n_press = '0; n_rel = '0;
          for (int i = 0; i < 4; i++) begin
            if (p[i] != m_db[i]) begin
              m_streak[i]++;
              if (m_streak[i] == DB) begin
                m_streak[i] = 0;
                n_db[i]     = ~m_db[i];
                n_press[i]  = ~m_db[i];
                n_rel[i]    = m_db[i];
              end
            end else begin
              m_streak[i] = 0;
            end
          end
          m_db = n_db; m_press = n_press; m_rel = n_rel;
          m_k2 = m_k1; m_k1 = key;
        end
      end

      // Every-cycle comparison against the model, plus pulse bookkeeping.
      forever begin
        @(negedge clk);
        n_tests++;
        if ({value, press, ledr, lock, wrap} !== {m_val, m_press, m_db, m_lock, m_wrap}) begin
          n_fail++;
          $display("FAIL model_cmp t=%0t: dut val=%h press=%b ledr=%b lock=%b wrap=%b, model val=%h press=%b ledr=%b lock=%b wrap=%b",
                   $time, value, press, ledr, lock, wrap, m_val, m_press, m_db, m_lock, m_wrap);
        end
        for (int i = 0; i < 4; i++) if (press[i] === 1'b1) press_tot[i]++;
        if (wrap === 1'b1) wrap_tot++;
        if (value !== prev_val) chg_tot++;
        prev_val = value;
      end
    join_none

    // 1: clean press of KEY[0]
    do_reset();
    check("reset_value", int'(value), 0);
    check("reset_outputs", int'({press, ledr, lock, wrap}), 0);
    snap();
    key[0] = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 6) check("t1_value_edge6", int'(value), 0);
      if (e == 7) check("t1_value_edge7", int'(value), 1);
      if (e == 7) check("t1_ledr_held", int'(ledr[0]), 1);
    end
    key[0] = 1'b1;
    repeat (20) tick();
    check("t1_press_count", press_tot[0] - s_press0, 1);
    check("t1_value_final", int'(value), 1);
    check("t1_ledr_released", int'(ledr[0]), 0);
    check("t1_value_changes", chg_tot - s_chg, 1);

    // 2: bouncing input then a solid hold
    do_reset();
    snap();
    for (int c = 0; c < 20; c++) begin
      key[0] = ((c / 2) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
    end
    key[0] = 1'b0;
    repeat (10) tick();
    key[0] = 1'b1;
    repeat (15) tick();
    check("t2_press_count", press_tot[0] - s_press0, 1);
    check("t2_value", int'(value), 1);

    // 3: wrap-around in both directions
    do_reset();
    snap();
    repeat (15) press_key(0);
    check("t3_value_F", int'(value), 15);
    check("t3_no_wrap", wrap_tot - s_wrap, 0);
    press_key(0);
    check("t3_wrap_up_value", int'(value), 0);
    check("t3_wrap_up_pulse", wrap_tot - s_wrap, 1);
    press_key(1);
    check("t3_wrap_dn_value", int'(value), 15);
    check("t3_wrap_dn_pulse", wrap_tot - s_wrap, 2);

    // 4: auto-repeat down from 9
    do_reset();
    repeat (9) press_key(0);
    check("t4_start_value", int'(value), 9);
    snap();
    key[1] = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (e == 7)  check("t4_press_step", int'(value), 8);
      if (e == 26) check("t4_before_delay", int'(value), 8);
      if (e == 27) check("t4_first_repeat", int'(value), 7);
      if (e == 31) check("t4_before_period", int'(value), 7);
      if (e == 32) check("t4_repeat_2", int'(value), 6);
      if (e == 37) check("t4_repeat_3", int'(value), 5);
    end
    key[1] = 1'b1;
    repeat (30) tick();
    check("t4_final_value", int'(value), 4);
    check("t4_step_count", chg_tot - s_chg, 5);

    // 5: lock behaviour
    do_reset();
    press_key(0);
    press_key(0);
    press_key(3);
    check("t5_locked", int'(lock), 1);
    press_key(0);
    check("t5_locked_inc_ignored", int'(value), 2);
    press_key(2);
    check("t5_clear_while_locked", int'(value), 0);
    press_key(3);
    check("t5_unlocked", int'(lock), 0);
    press_key(0);
    check("t5_inc_after_unlock", int'(value), 1);

    // 6: async reset in the middle of auto-repeat with the key held
    do_reset();
    key[0] = 1'b0;
    for (int e = 1; e <= 33; e++) begin
      tick();
      if (e == 32) check("t6_value_3", int'(value), 3);
    end
    rst_n = 1'b0;
    #1;
    check("t6_async_reset", int'({value, press, ledr, lock, wrap}), 0);
    #1;
    rst_n = 1'b1;
    snap();
    for (int e = 1; e <= 27; e++) begin
      tick();
      if (e == 6)  check("t6_post_edge6", int'(value), 0);
      if (e == 7)  check("t6_post_edge7", int'(value), 1);
      if (e == 27) check("t6_repeat_restart", int'(value), 2);
    end
    check("t6_press_count", press_tot[0] - s_press0, 1);
    key[0] = 1'b1;
    repeat (15) tick();

    // Randomised key activity, checked by the model every cycle
    do_reset();
    for (int it = 0; it < 40; it++) begin
      logic [3:0] mask;
      logic [1:0] b;
      int         dur;
      mask = 4'($urandom_range(0, 15));
      dur  = int'($urandom_range(1, 30));
      key  = ~mask;
      for (int c = 0; c < dur; c++) begin
        tick();
        if ($urandom_range(0, 7) == 0) begin
          b      = 2'($urandom_range(0, 3));
          key[b] = ~key[b];
        end
      end
      key = 4'hF;
      repeat ($urandom_range(0, 12)) tick();
    end
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
